// File: rtl/serial_pkg.sv
// Shared definitions for the buffered serial port: register offsets, STATUS layout
// and the sticky-flag clear mask.
package serial_pkg;

  localparam logic [31:0] DATA_OFF   = 32'd0;
  localparam logic [31:0] STATUS_OFF = 32'd1;

  localparam int ST_RXAVAIL   = 0;
  localparam int ST_TXFULL    = 1;
  localparam int ST_TXEMPTY   = 2;
  localparam int ST_RXOVER    = 3;
  localparam int ST_TXDROP    = 4;
  localparam int ST_RXUNDER   = 5;
  localparam int ST_RXCNT_LSB = 8;
  localparam int ST_TXCNT_LSB = 16;

  localparam logic [31:0] W1C_MASK = 32'h0000_0038;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_DATA_WR,
    ACC_DATA_RD,
    ACC_STAT_WR,
    ACC_STAT_RD
  } access_t;

  // Field order mirrors STATUS bits 5..3 so a W1C slice casts straight across.
  typedef struct packed {
    logic rxUnder;
    logic txDrop;
    logic rxOver;
  } sticky_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head; the head reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  // A push into a full FIFO is only taken when the same edge frees a slot.
  assign w_doPush = push && (!full || pop);
  assign w_doPop  = pop && !empty;

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/buffered_serial.sv
// Memory-mapped serial port: two-word register window on the operand bus, TX/RX
// FIFOs toward valid/ready byte streams, and a STATUS register with sticky errors.
module buffered_serial
  import serial_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'd32,
  parameter int          DATA_W   = 8,
  parameter int          TX_DEPTH = 4,
  parameter int          RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              rw,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic [31:0]       w_offset;
  logic              w_inRange;
  access_t           w_access;
  logic              w_txPush, w_txPop, w_txFull, w_txEmpty;
  logic [TX_CW-1:0]  w_txCount;
  logic              w_rxPush, w_rxPop, w_rxFull, w_rxEmpty;
  logic [RX_CW-1:0]  w_rxCount;
  logic [DATA_W-1:0] w_rxHead;
  logic [31:0]       w_w1c;
  logic [31:0]       w_status;
  logic [31:0]       w_rdataNext;
  sticky_t           w_evt, w_clr, w_stickyNext;
  logic              w_unusedWdata;

  logic              r_ack;
  logic [31:0]       r_rdata;
  sticky_t           r_sticky;

  // Offset subtraction keeps the window check safe when BASE sits near the top of memory.
  assign w_offset  = addr - BASE;
  assign w_inRange = enable && (addr >= BASE) && (w_offset < 32'd2);

  always_comb begin
    w_access = ACC_NONE;
    if (w_inRange) begin
      if (w_offset == DATA_OFF) begin
        w_access = rw ? ACC_DATA_WR : ACC_DATA_RD;
      end else begin
        w_access = rw ? ACC_STAT_WR : ACC_STAT_RD;
      end
    end
  end

  assign w_txPush = (w_access == ACC_DATA_WR);
  assign w_txPop  = tx_valid && tx_ready;
  assign tx_valid = !w_txEmpty;

  assign rx_ready = !w_rxFull;
  assign w_rxPush = rx_valid && rx_ready;
  assign w_rxPop  = (w_access == ACC_DATA_RD) && !w_rxEmpty;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_txFifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_txPush),
    .pop   (w_txPop),
    .wdata (wdata[DATA_W-1:0]),
    .rdata (tx_data),
    .full  (w_txFull),
    .empty (w_txEmpty),
    .count (w_txCount)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rxFifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_rxPush),
    .pop   (w_rxPop),
    .wdata (rx_data),
    .rdata (w_rxHead),
    .full  (w_rxFull),
    .empty (w_rxEmpty),
    .count (w_rxCount)
  );

  assign w_evt.txDrop  = w_txPush && w_txFull && !w_txPop;
  assign w_evt.rxOver  = rx_valid && w_rxFull;
  assign w_evt.rxUnder = (w_access == ACC_DATA_RD) && w_rxEmpty;
  assign w_w1c         = wdata & W1C_MASK;
  assign w_unusedWdata = ^wdata;

  always_comb begin
    w_clr = '0;
    if (w_access == ACC_STAT_RD) begin
      w_clr = '1;
    end else if (w_access == ACC_STAT_WR) begin
      w_clr = sticky_t'(w_w1c[ST_RXUNDER:ST_RXOVER]);
    end
  end

  // Events are OR-ed in after the clear so a same-cycle event survives a clear.
  assign w_stickyNext = sticky_t'((r_sticky & ~w_clr) | w_evt);

  always_comb begin
    w_status                        = '0;
    w_status[ST_RXAVAIL]            = !w_rxEmpty;
    w_status[ST_TXFULL]             = w_txFull;
    w_status[ST_TXEMPTY]            = w_txEmpty;
    w_status[ST_RXOVER]             = r_sticky.rxOver;
    w_status[ST_TXDROP]             = r_sticky.txDrop;
    w_status[ST_RXUNDER]            = r_sticky.rxUnder;
    w_status[ST_RXCNT_LSB +: 8]     = 8'(w_rxCount);
    w_status[ST_TXCNT_LSB +: 8]     = 8'(w_txCount);
  end

  always_comb begin
    w_rdataNext = '0;
    case (w_access)
      ACC_DATA_RD: w_rdataNext = 32'(w_rxHead);
      ACC_STAT_RD: w_rdataNext = w_status;
      default:     w_rdataNext = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack    <= 1'b0;
      r_rdata  <= '0;
      r_sticky <= '0;
    end else begin
      r_ack    <= w_inRange;
      r_rdata  <= w_rdataNext;
      r_sticky <= w_stickyNext;
    end
  end

  assign ack   = r_ack;
  assign rdata = r_rdata;

endmodule

// File: doc/buffered_serial.md
Name: buffered_serial

Overview:
- Memory-mapped serial port. Parametrised successor to the simulation serial device.
- Sits on the operand (port 0) bus next to the RAM, decoded by base address.
- Adds independent TX and RX FIFOs, a status register with sticky error flags, and valid/ready byte streams toward an external transmitter/receiver (or a testbench model). Replaces direct $putchar/$getchar.

Parameters:
- BASE, 32, first word address of the register window (window is 2 words).
- DATA_W, 8, character width in bits; 1..32.
- TX_DEPTH, 4, TX FIFO entries; power of two, >=2.
- RX_DEPTH, 4, RX FIFO entries; power of two, >=2.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  bus access strobe
- rw  in  1  1 = write, 0 = read
- addr  in  32  word address
- wdata  in  32  write data
- rdata  out  32  read data; zero when not returning a read
- ack  out  1  one-cycle pulse: in-range access completed
- tx_data  out  DATA_W  head of TX FIFO
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  sink accepts tx_data this cycle
- rx_data  in  DATA_W  incoming character
- rx_valid  in  1  rx_data present
- rx_ready  out  1  RX FIFO not full

Behaviour:
- Reset values:
  - FIFOs empty; pointers and counts 0.
  - rdata=0, ack=0, tx_valid=0, tx_data=0.
  - rx_ready=1; sticky flags 0.
- In range when BASE <= addr < BASE+2. Out-of-range accesses are ignored: no ack, no state change.
- Register map:
  - BASE+0 DATA write: push wdata[DATA_W-1:0] to TX. If TX is full, drop the character and set sticky TXDROP.
  - BASE+0 DATA read: pop RX head. rdata = zero-extended head. If RX is empty, rdata=0, set sticky RXUNDER, no pop.
  - BASE+1 STATUS read: bit0 RXAVAIL (rx count != 0), bit1 TXFULL, bit2 TXEMPTY, bit3 RXOVER, bit4 TXDROP, bit5 RXUNDER, bits[15:8] rx count, bits[23:16] tx count, others 0.
  - A STATUS read clears bits 3..5 in the same edge. A flag event in that same cycle wins: the flag is still set afterwards.
  - BASE+1 write: writing 1s to wdata[5:3] clears the matching sticky flags (write-1-to-clear). Other bits are ignored.
- Latency: access is sampled at edge N. ack=1 and rdata are valid during cycle N+1 (registered). rdata returns to 0 the following cycle.
  - Back-to-back accesses on consecutive cycles are allowed; each gets its own ack.
- TX stream:
  - tx_data/tx_valid come combinationally from the FIFO head.
  - A pop occurs on an edge where tx_valid && tx_ready.
- RX stream:
  - rx_ready = !rx_full. A push occurs on an edge where rx_valid && rx_ready.
  - rx_valid while full sets sticky RXOVER; the character is lost.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle: count is unchanged. This is legal even when full, and the bus push is accepted, not dropped, when the sink pops the same edge.
  - Legal when empty only for RX, where the push goes into the FIFO and the bus pop sees empty (RXUNDER). No bypass.
  - Pointers wrap modulo depth. Counts are $clog2(depth)+1 bits wide and never exceed depth.
- Reset asserted mid-operation: immediately returns all state to reset values. In-flight ack is suppressed; FIFO contents are discarded.

Decomposition:
- Shared package (serial_pkg):
  - register offsets (DATA_OFF=0, STATUS_OFF=1)
  - STATUS bit positions
  - the W1C mask
- Sub-module sync_fifo:
  - parameters WIDTH and DEPTH
  - ports push, pop, wdata, rdata (head), full, empty, count
  - async reset
  - instantiated twice: TX and RX

Test Plan:
- Reset, then read BASE+1 -> ack in the next cycle, rdata=32'h0000_0004 (TXEMPTY only), rx_ready=1, tx_valid=0.
- With tx_ready=0, write 'A','B','C','D','E' to BASE+0 -> after 4 writes STATUS bit1=1 and tx count=4. 'E' is dropped and TXDROP is set. Raise tx_ready -> tx_data sequence 41,42,43,44, then tx_valid=0.
- Drive rx_valid with 0x31..0x35 over 5 cycles -> rx_ready=0 after 4, RXOVER=1. Four DATA reads return 0x31..0x34; a fifth read returns 0 with RXUNDER=1.
- TX full with tx_ready=1 and a bus write in the same cycle -> write accepted, TXDROP stays 0, count stays 4.
- Read STATUS with RXOVER=1 -> bit3=1 returned. Next STATUS read -> bit3=0. Separately, write 0x38 to BASE+1 -> sticky bits cleared.
- Assert reset for 1 cycle mid-transfer with 2 entries in each FIFO -> next cycle tx_valid=0, STATUS=0x4, no ack for an access sampled during reset. Access at addr BASE+2 -> no ack, no state change.
